// File: rtl/snn_pkg.sv
// Shared types and constants for the two-layer SNN training controller:
// FSM states, weight saturation limits, packet address map and learning-rule codes.
package snn_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL1  = 3'd1,
        S_EVAL2  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int WMAX = 7;
    localparam int WMIN = -8;

    localparam logic [3:0] A_W1      = 4'd0;
    localparam logic [3:0] A_W2      = 4'd1;
    localparam logic [3:0] A_W3      = 4'd2;
    localparam logic [3:0] A_W4      = 4'd3;
    localparam logic [3:0] A_W5      = 4'd4;
    localparam logic [3:0] A_W6      = 4'd5;
    localparam logic [3:0] A_THR1_LO = 4'd6;
    localparam logic [3:0] A_THR1_HI = 4'd7;
    localparam logic [3:0] A_THR2_LO = 4'd8;
    localparam logic [3:0] A_THR2_HI = 4'd9;

    // Encoded as {o fired, h fired}
    typedef enum logic [1:0] {
        R_HOLD   = 2'b00,
        R_H_ONLY = 2'b01,
        R_O_ONLY = 2'b10,
        R_BOTH   = 2'b11
    } rule_t;

endpackage

// File: rtl/snn_sat_step.sv
// Combinational saturating +1 / -1 / hold step for one signed synaptic weight.
// The limit test precedes the add so the weight can never wrap.
module snn_sat_step
    import snn_pkg::*;
#(
    parameter int WW = 4
) (
    input  rule_t                 rule,
    input  logic signed [WW-1:0]  w,
    output logic signed [WW-1:0]  w_next
);

    localparam logic signed [WW-1:0] W_MAX = WW'(WMAX);
    localparam logic signed [WW-1:0] W_MIN = WW'(WMIN);
    localparam logic signed [WW-1:0] ONE   = WW'(1);

    function automatic logic signed [WW-1:0] sat_step(
        input logic signed [WW-1:0] wv,
        input rule_t                r
    );
        logic signed [WW-1:0] res;
        res = wv;
        case (r)
            R_BOTH:             res = (wv == W_MAX) ? wv : wv + ONE;
            R_H_ONLY, R_O_ONLY: res = (wv == W_MIN) ? wv : wv - ONE;
            default:            res = wv;
        endcase
        return res;
    endfunction

    assign w_next = sat_step(w, rule);

endmodule

// File: rtl/snn_train_ctrl.sv
// Sequencer and weight/threshold store for the two-layer spiking network:
// packet-loaded register file plus an EVAL1/EVAL2/UPDATE/DONE pass with reward-gated learning.
module snn_train_ctrl
    import snn_pkg::*;
#(
    parameter int WW = 4,
    parameter int TW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_mode,
    input  logic              packet_valid,
    input  logic [7:0]        packet,
    input  logic              start,
    input  logic              reward,
    input  logic [1:0]        spike_h,
    input  logic [1:0]        spike_o,
    output logic [6*WW-1:0]   weights,
    output logic [TW-1:0]     thr1,
    output logic [TW-1:0]     thr2,
    output logic              eval_l1,
    output logic              eval_l2,
    output logic              busy,
    output logic              done,
    output logic [3:0]        addr_int,
    output logic              cfg_err
);

    state_t state, state_nxt;

    logic signed [WW-1:0] w1, w2, w3, w4;
    logic        [WW-1:0] w5, w6;
    logic signed [WW-1:0] w1_nxt, w2_nxt, w3_nxt, w4_nxt;

    logic [1:0] spk_h_p1;
    logic [1:0] spk_o_p2;

    logic [3:0] pkt_addr;
    logic [3:0] pkt_data;
    logic       pkt_req;
    logic       addr_ok;
    logic       pkt_acc;
    logic       pkt_rej;
    logic       learn;

    // ---- FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state and phase strobes
    always_comb begin
        state_nxt = state;
        eval_l1   = 1'b0;
        eval_l2   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !write_mode) begin
                    state_nxt = S_EVAL1;
                end
            end
            S_EVAL1: begin
                eval_l1   = 1'b1;
                state_nxt = S_EVAL2;
            end
            S_EVAL2: begin
                eval_l2   = 1'b1;
                state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---- spike latches: hidden layer at end of EVAL1, output layer at end of EVAL2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_h_p1 <= 2'b00;
            spk_o_p2 <= 2'b00;
        end else begin
            if (state == S_EVAL1) spk_h_p1 <= spike_h;
            if (state == S_EVAL2) spk_o_p2 <= spike_o;
        end
    end

    // ---- packet decode
    assign pkt_addr = packet[7:4];
    assign pkt_data = packet[3:0];
    assign pkt_req  = write_mode && packet_valid;
    assign addr_ok  = (pkt_addr <= A_THR2_HI);
    assign pkt_acc  = pkt_req && (state == S_IDLE) && addr_ok;
    assign pkt_rej  = pkt_req && ((state != S_IDLE) || !addr_ok);

    // ---- learning step per synapse: w1 A->O0, w2 A->O1, w3 B->O0, w4 B->O1
    snn_sat_step #(.WW(WW)) u_step_w1 (
        .rule   (rule_t'({spk_o_p2[0], spk_h_p1[0]})),
        .w      (w1),
        .w_next (w1_nxt)
    );
    snn_sat_step #(.WW(WW)) u_step_w2 (
        .rule   (rule_t'({spk_o_p2[1], spk_h_p1[0]})),
        .w      (w2),
        .w_next (w2_nxt)
    );
    snn_sat_step #(.WW(WW)) u_step_w3 (
        .rule   (rule_t'({spk_o_p2[0], spk_h_p1[1]})),
        .w      (w3),
        .w_next (w3_nxt)
    );
    snn_sat_step #(.WW(WW)) u_step_w4 (
        .rule   (rule_t'({spk_o_p2[1], spk_h_p1[1]})),
        .w      (w4),
        .w_next (w4_nxt)
    );

    assign learn = (state == S_UPDATE) && reward;

    // ---- register file: packet writes only in IDLE, learning only in UPDATE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1       <= '0;
            w2       <= '0;
            w3       <= '0;
            w4       <= '0;
            w5       <= '0;
            w6       <= '0;
            thr1     <= TW'(1);
            thr2     <= TW'(1);
            addr_int <= 4'd0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= pkt_rej;
            if (pkt_acc) begin
                addr_int <= pkt_addr;
                case (pkt_addr)
                    A_W1:      w1        <= WW'(pkt_data);
                    A_W2:      w2        <= WW'(pkt_data);
                    A_W3:      w3        <= WW'(pkt_data);
                    A_W4:      w4        <= WW'(pkt_data);
                    A_W5:      w5        <= WW'(pkt_data);
                    A_W6:      w6        <= WW'(pkt_data);
                    A_THR1_LO: thr1[3:0] <= pkt_data;
                    A_THR1_HI: thr1[7:4] <= pkt_data;
                    A_THR2_LO: thr2[3:0] <= pkt_data;
                    A_THR2_HI: thr2[7:4] <= pkt_data;
                    default:   ;
                endcase
            end else if (learn) begin
                w1 <= w1_nxt;
                w2 <= w2_nxt;
                w3 <= w3_nxt;
                w4 <= w4_nxt;
            end
        end
    end

    assign weights = {w6, w5, w4, w3, w2, w1};

endmodule

// File: tb/tb_snn_train_ctrl.sv
// Directed self-checking bench for snn_train_ctrl: reset, configuration,
// learning passes with saturation, contention and reset during a pass.
module tb_snn_train_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_mode;
    logic        packet_valid;
    logic [7:0]  packet;
    logic        start;
    logic        reward;
    logic [1:0]  spike_h;
    logic [1:0]  spike_o;
    logic [23:0] weights;
    logic [7:0]  thr1;
    logic [7:0]  thr2;
    logic        eval_l1;
    logic        eval_l2;
    logic        busy;
    logic        done;
    logic [3:0]  addr_int;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    snn_train_ctrl #(.WW(4), .TW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_mode   (write_mode),
        .packet_valid (packet_valid),
        .packet       (packet),
        .start        (start),
        .reward       (reward),
        .spike_h      (spike_h),
        .spike_o      (spike_o),
        .weights      (weights),
        .thr1         (thr1),
        .thr2         (thr2),
        .eval_l1      (eval_l1),
        .eval_l2      (eval_l2),
        .busy         (busy),
        .done         (done),
        .addr_int     (addr_int),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] p);
        write_mode   = 1'b1;
        packet_valid = 1'b1;
        packet       = p;
        tick();
        packet_valid = 1'b0;
        write_mode   = 1'b0;
    endtask

    task automatic run_pass(input string tag, input logic [1:0] sh, input logic [1:0] so,
                            input logic rw, input logic [23:0] exp_w);
        spike_h = sh;
        spike_o = so;
        reward  = rw;
        start   = 1'b1;
        tick();
        chk({tag, "_eval1"}, 32'(eval_l1), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        start = 1'b0;
        tick();
        chk({tag, "_eval2"}, 32'(eval_l2), 32'd1);
        spike_h = ~sh;
        tick();
        chk({tag, "_upd_nodone"}, 32'(done), 32'd0);
        spike_o = ~so;
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_weights"}, 32'(weights), 32'(exp_w));
        tick();
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        spike_h = 2'b00;
        spike_o = 2'b00;
    endtask

    initial begin
        rst_n        = 1'b0;
        write_mode   = 1'b0;
        packet_valid = 1'b0;
        packet       = 8'h00;
        start        = 1'b0;
        reward       = 1'b0;
        spike_h      = 2'b00;
        spike_o      = 2'b00;
        repeat (2) tick();

        // Reset values
        chk("rst_weights", 32'(weights), 32'h000000);
        chk("rst_thr1", 32'(thr1), 32'h01);
        chk("rst_thr2", 32'(thr2), 32'h01);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(addr_int), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // start ignored in configuration mode
        write_mode = 1'b1;
        start      = 1'b1;
        tick();
        chk("wm_start_ignored", 32'(busy), 32'd0);
        start      = 1'b0;
        write_mode = 1'b0;

        // Configuration packets
        send_pkt(8'h03);
        chk("cfg_w1", 32'(weights), 32'h000003);
        chk("cfg_addr0", 32'(addr_int), 32'd0);
        send_pkt(8'h7A);
        chk("cfg_thr1", 32'(thr1), 32'hA1);
        chk("cfg_addr7", 32'(addr_int), 32'd7);
        send_pkt(8'hC5);
        chk("cfg_bad_err", 32'(cfg_err), 32'd1);
        chk("cfg_bad_addr", 32'(addr_int), 32'd7);
        chk("cfg_bad_thr1", 32'(thr1), 32'hA1);
        chk("cfg_bad_w", 32'(weights), 32'h000003);
        tick();
        chk("cfg_err_pulse", 32'(cfg_err), 32'd0);
        send_pkt(8'h8C);
        send_pkt(8'h93);
        chk("cfg_thr2", 32'(thr2), 32'h3C);
        chk("cfg_addr9", 32'(addr_int), 32'd9);
        send_pkt(8'hA0);
        chk("cfg_addr10_err", 32'(cfg_err), 32'd1);
        chk("cfg_addr10_keep", 32'(addr_int), 32'd9);

        // Learning pass from zero weights, w5/w6 preloaded to watch they stay put
        send_pkt(8'h00);
        send_pkt(8'h10);
        send_pkt(8'h20);
        send_pkt(8'h30);
        send_pkt(8'h45);
        send_pkt(8'h5A);
        run_pass("learn", 2'b01, 2'b01, 1'b1, 24'hA50FF1);

        // Saturation at +7 and -8
        send_pkt(8'h07);
        send_pkt(8'h18);
        send_pkt(8'h20);
        send_pkt(8'h30);
        run_pass("sat", 2'b01, 2'b01, 1'b1, 24'hA50F87);
        run_pass("noreward", 2'b11, 2'b11, 1'b0, 24'hA50F87);
        run_pass("learn_b", 2'b10, 2'b10, 1'b1, 24'hA51E87);
        chk("thr_untouched", 32'({thr1, thr2}), 32'hA13C);

        // Contention: start held, packet during EVAL2
        reward = 1'b1;
        start  = 1'b1;
        tick();
        chk("cont_eval1_a", 32'(eval_l1), 32'd1);
        tick();
        chk("cont_eval2_a", 32'(eval_l2), 32'd1);
        write_mode   = 1'b1;
        packet_valid = 1'b1;
        packet       = 8'h0F;
        tick();
        chk("cont_err", 32'(cfg_err), 32'd1);
        write_mode   = 1'b0;
        packet_valid = 1'b0;
        tick();
        chk("cont_done_a", 32'(done), 32'd1);
        chk("cont_weights", 32'(weights), 32'hA51E87);
        chk("cont_addr", 32'(addr_int), 32'd3);
        tick();
        chk("cont_idle", 32'(busy), 32'd0);
        tick();
        chk("cont_eval1_b", 32'(eval_l1), 32'd1);
        tick();
        tick();
        tick();
        chk("cont_done_b", 32'(done), 32'd1);
        start = 1'b0;
        tick();
        tick();
        chk("cont_no_queue", 32'(busy), 32'd0);

        // Reset during UPDATE
        spike_h = 2'b01;
        spike_o = 2'b01;
        reward  = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_in_update", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_weights", 32'(weights), 32'h000000);
        chk("mid_thr", 32'({thr1, thr2}), 32'h0101);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_addr", 32'(addr_int), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        run_pass("after_rst", 2'b01, 2'b01, 1'b1, 24'h000FF1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
